// File: rtl/rst_seq_sync.sv
// rst_seq_sync: reset synchronizer and ordered release sequencer for one
// clock domain. RST asynchronously asserts every channel reset; release is
// synchronized through a NUM_STAGES flop chain, held for MIN_HOLD cycles,
// then channels are released one by one (bit 0 first) with GAP+1 cycles
// between consecutive releases.
//
// Ports:
//   CLK       destination-domain clock
//   RST       asynchronous active-high reset
//   SW_RST    synchronous software reset request (active-high, level)
//   GAP       extra idle cycles between channel releases (latched per sequence)
//   SYNC_RST  per-channel active-low resets, contiguous ones from bit 0
//   RST_DONE  high once every channel is released
//
// Build option: define RST_SEQ_SW_RST_EN to make SW_RST functional; when
// undefined the port is kept but ignored.

module rst_seq_sync #(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned MIN_HOLD   = 4,
    parameter int unsigned GAP_W      = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SW_RST,
    input  logic [GAP_W-1:0]  GAP,
    output logic [NUM_CH-1:0] SYNC_RST,
    output logic              RST_DONE
);

    localparam int unsigned HOLD_W = (MIN_HOLD < 2) ? 1 : $clog2(MIN_HOLD);
    localparam int unsigned IDX_W  = (NUM_CH < 2) ? 1 : $clog2(NUM_CH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] CH_ONE    = NUM_CH'(1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_STAGES-1:0] sync_q;
    logic                sync_ok;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [GAP_W-1:0]    gap_q;
    logic [IDX_W-1:0]    idx;
    logic                sw_eff;

    // Software reset request, forced inactive when the feature is not built
`ifdef RST_SEQ_SW_RST_EN
    assign sw_eff = SW_RST;
`else
    logic unused_sw_rst;
    assign unused_sw_rst = SW_RST;
    assign sw_eff        = 1'b0;
`endif

    // Synchronizer chain: only RST clears it, software reset leaves it full
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[NUM_STAGES-1];

    // Release sequencer with registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            gap_q    <= '0;
            idx      <= '0;
            SYNC_RST <= '0;
            RST_DONE <= 1'b0;
        end else if (sw_eff) begin
            // Wins over any release scheduled on this edge
            state    <= ST_HOLD;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            SYNC_RST <= '0;
            RST_DONE <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    SYNC_RST <= '0;
                    RST_DONE <= 1'b0;
                    if (!sync_ok) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        // This edge is the MIN_HOLD-th qualifying edge
                        hold_cnt <= '0;
                        SYNC_RST <= CH_ONE;
                        gap_cnt  <= '0;
                        if (NUM_CH == 1) begin
                            state    <= ST_DONE;
                            RST_DONE <= 1'b1;
                        end else begin
                            state <= ST_RELEASE;
                            idx   <= IDX_W'(1);
                            gap_q <= GAP;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                ST_RELEASE: begin
                    // gap_q+1 edges per channel; GAP changes wait for the next run
                    if (gap_cnt == gap_q) begin
                        gap_cnt  <= '0;
                        SYNC_RST <= SYNC_RST | (CH_ONE << idx);
                        idx      <= idx + IDX_W'(1);
                        if (idx == IDX_LAST) begin
                            state    <= ST_DONE;
                            RST_DONE <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                ST_DONE: begin
                    SYNC_RST <= '1;
                    RST_DONE <= 1'b1;
                end

                default: begin
                    state    <= ST_HOLD;
                    hold_cnt <= '0;
                    gap_cnt  <= '0;
                    idx      <= '0;
                    SYNC_RST <= '0;
                    RST_DONE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_sync.sv
// tb_rst_seq_sync: directed vector bench for rst_seq_sync at default
// parameters (NUM_STAGES=2, NUM_CH=3, MIN_HOLD=4, GAP_W=4).

module tb_rst_seq_sync;

    logic       clk;
    logic       rst;
    logic       sw_rst;
    logic [3:0] gap;
    logic [2:0] sync_rst;
    logic       rst_done;

    int unsigned total;
    int unsigned bad;

    rst_seq_sync dut (
        .CLK      (clk),
        .RST      (rst),
        .SW_RST   (sw_rst),
        .GAP      (gap),
        .SYNC_RST (sync_rst),
        .RST_DONE (rst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: drive inputs, advance n edges (0 = no edge), then compare
    typedef struct {
        logic        rst;
        logic        sw;
        logic [3:0]  gap;
        int unsigned n;
        logic [2:0]  sr;
        logic        done;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic [3:0] g,
                                input int unsigned n, input logic [2:0] sr,
                                input logic d, input string name);
        vec_t v;
        v.rst = r; v.sw = s; v.gap = g; v.n = n; v.sr = sr; v.done = d; v.name = name;
        return v;
    endfunction

    task automatic tick(input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [2:0] exp_sr, input logic exp_done);
        total++;
        if (sync_rst !== exp_sr || rst_done !== exp_done) begin
            bad++;
            $display("FAIL %s: got SYNC_RST=%b RST_DONE=%b, want SYNC_RST=%b RST_DONE=%b",
                     name, sync_rst, rst_done, exp_sr, exp_done);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        sw_rst = 1'b0;
        gap    = 4'd3;

        // GAP=3: releases at E6, E10, E14
        vecs.push_back(mk(1, 0, 3, 2,  3'b000, 0, "reset_state"));
        vecs.push_back(mk(0, 0, 3, 5,  3'b000, 0, "g3_hold_E5"));
        vecs.push_back(mk(0, 0, 3, 1,  3'b001, 0, "g3_rel0_E6"));
        vecs.push_back(mk(0, 0, 3, 3,  3'b001, 0, "g3_gap_E9"));
        vecs.push_back(mk(0, 0, 3, 1,  3'b011, 0, "g3_rel1_E10"));
        vecs.push_back(mk(0, 0, 3, 3,  3'b011, 0, "g3_gap_E13"));
        vecs.push_back(mk(0, 0, 3, 1,  3'b111, 1, "g3_rel2_E14"));
        vecs.push_back(mk(0, 0, 3, 4,  3'b111, 1, "g3_done_hold"));
        // Async assert from DONE, then GAP=0: releases at E6, E7, E8
        vecs.push_back(mk(1, 0, 0, 0,  3'b000, 0, "async_from_done"));
        vecs.push_back(mk(1, 0, 0, 1,  3'b000, 0, "g0_reset"));
        vecs.push_back(mk(0, 0, 0, 5,  3'b000, 0, "g0_hold_E5"));
        vecs.push_back(mk(0, 0, 0, 1,  3'b001, 0, "g0_rel0_E6"));
        vecs.push_back(mk(0, 0, 0, 1,  3'b011, 0, "g0_rel1_E7"));
        vecs.push_back(mk(0, 0, 0, 1,  3'b111, 1, "g0_rel2_E8"));
        // Short RST pulse mid-RELEASE clears without a clock, sequence restarts
        vecs.push_back(mk(1, 0, 3, 1,  3'b000, 0, "mid_reset"));
        vecs.push_back(mk(0, 0, 3, 10, 3'b011, 0, "mid_E10"));
        vecs.push_back(mk(1, 0, 3, 0,  3'b000, 0, "mid_async_clear"));
        vecs.push_back(mk(0, 0, 3, 5,  3'b000, 0, "mid_rerun_E5"));
        vecs.push_back(mk(0, 0, 3, 1,  3'b001, 0, "mid_rerun_E6"));
        vecs.push_back(mk(0, 0, 3, 8,  3'b111, 1, "mid_rerun_E14"));
        // GAP 3->0 after first release: spacing stays 4 for this run
        vecs.push_back(mk(1, 0, 3, 1,  3'b000, 0, "gchg_reset"));
        vecs.push_back(mk(0, 0, 3, 6,  3'b001, 0, "gchg_rel0_E6"));
        vecs.push_back(mk(0, 0, 0, 3,  3'b001, 0, "gchg_keep_E9"));
        vecs.push_back(mk(0, 0, 0, 1,  3'b011, 0, "gchg_rel1_E10"));
        vecs.push_back(mk(0, 0, 0, 3,  3'b011, 0, "gchg_keep_E13"));
        vecs.push_back(mk(0, 0, 0, 1,  3'b111, 1, "gchg_rel2_E14"));
        // Next run picks up GAP=0
        vecs.push_back(mk(1, 0, 0, 1,  3'b000, 0, "gnext_reset"));
        vecs.push_back(mk(0, 0, 0, 6,  3'b001, 0, "gnext_rel0_E6"));
        vecs.push_back(mk(0, 0, 0, 1,  3'b011, 0, "gnext_rel1_E7"));
        vecs.push_back(mk(0, 0, 0, 1,  3'b111, 1, "gnext_rel2_E8"));

        foreach (vecs[i]) begin
            rst    = vecs[i].rst;
            sw_rst = vecs[i].sw;
            gap    = vecs[i].gap;
            if (vecs[i].n == 0) #1;
            else tick(vecs[i].n);
            check(vecs[i].name, vecs[i].sr, vecs[i].done);
        end

`ifdef RST_SEQ_SW_RST_EN
        // Software reset for 2 cycles from DONE, GAP=3: S4, S8, S12
        gap    = 4'd3;
        sw_rst = 1'b1;
        tick(1);
        check("sw_first_edge", 3'b000, 1'b0);
        tick(1);
        check("sw_second_edge", 3'b000, 1'b0);
        sw_rst = 1'b0;
        tick(3);
        check("sw_hold_S3", 3'b000, 1'b0);
        tick(1);
        check("sw_rel0_S4", 3'b001, 1'b0);
        tick(3);
        check("sw_gap_S7", 3'b001, 1'b0);
        tick(1);
        check("sw_rel1_S8", 3'b011, 1'b0);
        tick(3);
        check("sw_gap_S11", 3'b011, 1'b0);
        tick(1);
        check("sw_rel2_S12", 3'b111, 1'b1);

        // SW_RST on the edge of a scheduled release cancels it
        sw_rst = 1'b1;
        tick(1);
        sw_rst = 1'b0;
        tick(4);
        check("cancel_rel0_S4", 3'b001, 1'b0);
        tick(3);
        sw_rst = 1'b1;
        tick(1);
        check("cancel_at_S8", 3'b000, 1'b0);
        sw_rst = 1'b0;
        tick(3);
        check("cancel_hold_S3", 3'b000, 1'b0);
        tick(1);
        check("cancel_rerel0_S4", 3'b001, 1'b0);
`else
        // Feature not built: SW_RST toggles in DONE are ignored
        for (int k = 0; k < 4; k++) begin
            sw_rst = ~sw_rst;
            tick(2);
            check("sw_ignored", 3'b111, 1'b1);
        end
        sw_rst = 1'b1;
        tick(6);
        check("sw_ignored_long", 3'b111, 1'b1);
        sw_rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
